// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg
// Shared types and sizes for the cache-to-DRAM block bridge.
//   bridge_state_e : IDLE / RD / WR / DONE
//   get_word()     : pick one 32-bit word out of a 128-bit line
package mem_bridge_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int BLOCK_ADDR_W    = 28;
  localparam int BEAT_W          = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } bridge_state_e;

  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] line,
                                                 input logic [BEAT_W-1:0]  idx);
    return line[int'(idx)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/mem_beat_timer.sv
// mem_beat_timer
// Per-beat wait counter. Counts cycles the beat request is outstanding
// without an acknowledge and raises a single-cycle timeout when the count
// is about to reach TIMEOUT-1.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   req_i     : beat request currently outstanding
//   ack_i     : beat acknowledge
//   timeout_o : beat has waited too long; abort this cycle
module mem_beat_timer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires in the cycle whose edge would take the counter to TIMEOUT-1, so the
  // request is high for exactly TIMEOUT-1 cycles before it is dropped.
  assign timeout_o = req_i && !ack_i && (cnt_q == LAST_WAIT);

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || ack_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_block_bridge.sv
// mem_block_bridge
// Turns one 128-bit cache block read/write into four 32-bit req/ack beats on
// the word-wide DRAM port and returns the line with a one-cycle mem_ready.
// Ports:
//   clk, proc_reset          : clock and asynchronous active-high reset
//   mem_read, mem_write      : cache block requests, held until mem_ready
//   mem_addr, mem_wdata      : block address and write-back line
//   mem_rdata, mem_ready     : assembled read line and completion pulse
//   dram_req/we/addr/wdata   : word-beat request to memory
//   dram_rdata, dram_ack     : word-beat response
//   bus_err                  : sticky beat-timeout flag
// Optional build macro MEM_BLOCK_BRIDGE_STATS_EN adds rd_cnt/wr_cnt, saturating
// counts of completed (or aborted) read and write transactions.
//
// state | meaning
// IDLE  | waiting for a request (ignored in the cycle right after DONE)
// RD    | issuing read beat 'beat_q', filling the line buffer
// WR    | issuing write beat 'beat_q' from the latched line
// DONE  | one-cycle mem_ready to the cache
module mem_block_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         dram_req,
  output logic         dram_we,
  output logic [29:0]  dram_addr,
  output logic [31:0]  dram_wdata,
  input  logic [31:0]  dram_rdata,
  input  logic         dram_ack,
  output logic         bus_err
`ifdef MEM_BLOCK_BRIDGE_STATS_EN
  ,
  output logic [15:0]  rd_cnt,
  output logic [15:0]  wr_cnt
`endif
);

  bridge_state_e              state_q, state_d;
  logic [BLOCK_ADDR_W-1:0]    addr_q, addr_d;
  logic [BLOCK_W-1:0]         wdata_q, wdata_d;
  logic [BLOCK_W-1:0]         line_q, line_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic                       bus_err_q, bus_err_d;
  logic                       gap_q;
  logic                       beat_timeout;

  mem_beat_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_beat_timer (
    .clk       (clk),
    .rst       (proc_reset),
    .req_i     (dram_req),
    .ack_i     (dram_ack),
    .timeout_o (beat_timeout)
  );

  // Outputs decode straight from registers so reset clears them asynchronously.
  assign dram_req   = (state_q == RD) || (state_q == WR);
  assign dram_we    = (state_q == WR);
  assign dram_addr  = {addr_q, beat_q};
  assign dram_wdata = get_word(wdata_q, beat_q);
  assign mem_ready  = (state_q == DONE);
  assign mem_rdata  = line_q;
  assign bus_err    = bus_err_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    line_d    = line_q;
    beat_d    = beat_q;
    bus_err_d = bus_err_q | beat_timeout;
    case (state_q)
      IDLE: begin
        // gap_q blocks the request the cache is still holding after mem_ready.
        if (!gap_q) begin
          if (mem_write) begin
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            beat_d  = '0;
            state_d = WR;
          end else if (mem_read) begin
            addr_d  = mem_addr;
            beat_d  = '0;
            state_d = RD;
          end
        end
      end
      RD, WR: begin
        if (dram_ack) begin
          if (state_q == RD) begin
            line_d[int'(beat_q)*WORD_W +: WORD_W] = dram_rdata;
          end
          if (beat_q == BEAT_W'(WORDS_PER_BLOCK - 1)) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (beat_timeout) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      line_q    <= '0;
      beat_q    <= '0;
      bus_err_q <= 1'b0;
      gap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      line_q    <= line_d;
      beat_q    <= beat_d;
      bus_err_q <= bus_err_d;
      gap_q     <= (state_q == DONE);
    end
  end

`ifdef MEM_BLOCK_BRIDGE_STATS_EN
  logic        wr_txn_q;
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      wr_txn_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      // Remember the direction of the running transaction for its DONE cycle.
      if ((state_q == RD) || (state_q == WR)) begin
        wr_txn_q <= (state_q == WR);
      end
      if (state_q == DONE) begin
        if (wr_txn_q) begin
          if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end else begin
          if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
      end
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_block_bridge.sv
// tb_mem_block_bridge
// Directed bench for mem_block_bridge (TIMEOUT=8) with a small word-memory
// responder: configurable wait cycles, a no-ack mode and stray acks while idle.
module tb_mem_block_bridge;

  logic         clk;
  logic         proc_reset;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         dram_req;
  logic         dram_we;
  logic [29:0]  dram_addr;
  logic [31:0]  dram_wdata;
  logic [31:0]  dram_rdata;
  logic         dram_ack;
  logic         bus_err;
`ifdef MEM_BLOCK_BRIDGE_STATS_EN
  logic [15:0]  rd_cnt;
  logic [15:0]  wr_cnt;
`endif

  mem_block_bridge #(
    .TIMEOUT (8),
    .CNT_W   (7)
  ) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .dram_req   (dram_req),
    .dram_we    (dram_we),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .dram_ack   (dram_ack),
    .bus_err    (bus_err)
`ifdef MEM_BLOCK_BRIDGE_STATS_EN
    ,
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
`endif
  );

  int vecs = 0;
  int errs = 0;
  int ready_cnt = 0;

  int          mem_wait;
  bit          mem_noack;
  bit          stray_ack;
  logic [31:0] rd_base;

  logic [29:0] log_addr[$];
  logic        log_we[$];
  logic [31:0] log_wd[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: decides the ack for the coming edge at each falling edge.
  initial begin
    int wcnt;
    wcnt = 0;
    dram_ack = 1'b0;
    dram_rdata = '0;
    forever begin
      @(negedge clk);
      if (dram_req && !mem_noack && !proc_reset) begin
        if (wcnt >= mem_wait) begin
          dram_ack   = 1'b1;
          dram_rdata = rd_base + 32'(dram_addr[1:0]);
          log_addr.push_back(dram_addr);
          log_we.push_back(dram_we);
          log_wd.push_back(dram_wdata);
          wcnt = 0;
        end else begin
          dram_ack = 1'b0;
          wcnt++;
        end
      end else begin
        dram_ack   = stray_ack;
        dram_rdata = 32'hDEAD_BEEF;
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_ready) ready_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_wd.delete();
  endtask

  // Issues one request from a falling edge, scrambles the inputs after
  // acceptance, waits for mem_ready and then holds the request through the
  // post-DONE cycle like the cache does. chain_rd raises mem_read at ready.
  task automatic xfer(input logic we, input logic [27:0] addr, input logic [127:0] wd,
                      input logic chain_rd, output int lat, output int reqc);
    int n;
    bit done;
    mem_addr  = addr;
    mem_wdata = wd;
    if (we) mem_write = 1'b1;
    else    mem_read  = 1'b1;
    n = 0;
    reqc = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        mem_addr  = ~addr;
        mem_wdata = ~wd;
      end
      if (dram_req) reqc++;
      if (mem_ready) done = 1'b1;
    end
    chk("ready_seen", 128'(done), 128'd1);
    lat = n + 1;
    if (chain_rd) mem_read = 1'b1;
    @(negedge clk);
    chk("ready_one_cycle", 128'(mem_ready), 128'd0);
    @(negedge clk);
    chk("no_dup_request", 128'(dram_req), 128'd0);
    mem_write = 1'b0;
    if (!chain_rd) mem_read = 1'b0;
  endtask

  initial begin
    int lat;
    int reqc;
    int rc0;
    logic [127:0] wd;

    proc_reset = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wait   = 0;
    mem_noack  = 1'b0;
    stray_ack  = 1'b0;
    rd_base    = '0;
    repeat (2) @(negedge clk);

    chk("rst_mem_ready",  128'(mem_ready),  128'd0);
    chk("rst_dram_req",   128'(dram_req),   128'd0);
    chk("rst_dram_we",    128'(dram_we),    128'd0);
    chk("rst_dram_addr",  128'(dram_addr),  128'd0);
    chk("rst_dram_wdata", 128'(dram_wdata), 128'd0);
    chk("rst_mem_rdata",  mem_rdata,        128'd0);
    chk("rst_bus_err",    128'(bus_err),    128'd0);
    proc_reset = 1'b0;
    @(negedge clk);

    // Zero-wait read of block 0x10.
    rd_base = 32'hA0;
    clear_log();
    xfer(1'b0, 28'h0000010, '0, 1'b0, lat, reqc);
    chk("rd_latency", 128'(lat), 128'd6);
    chk("rd_beats", 128'(log_addr.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      chk("rd_addr", 128'((k < log_addr.size()) ? log_addr[k] : 30'h3FFFFFFF), 128'(30'h40 + k));
    end
    chk("rd_line", mem_rdata, 128'h000000A3_000000A2_000000A1_000000A0);

    // Write with two wait cycles per beat.
    mem_wait = 2;
    clear_log();
    wd = {32'h44, 32'h33, 32'h22, 32'h11};
    xfer(1'b1, 28'h0000001, wd, 1'b0, lat, reqc);
    chk("wr_latency", 128'(lat), 128'd14);
    chk("wr_beats", 128'(log_addr.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      chk("wr_addr", 128'((k < log_addr.size()) ? log_addr[k] : 30'h3FFFFFFF), 128'(30'h4 + k));
      chk("wr_we",   128'((k < log_we.size())   ? log_we[k]   : 1'b0),         128'd1);
      chk("wr_data", 128'((k < log_wd.size())   ? log_wd[k]   : 32'hFFFFFFFF), 128'(32'h11 * (k + 1)));
    end
    chk("wr_keeps_line", mem_rdata, 128'h000000A3_000000A2_000000A1_000000A0);

    // Write-back immediately followed by a refill read held through its ready.
    mem_wait = 0;
    rd_base  = 32'hB0;
    clear_log();
    rc0 = ready_cnt;
    xfer(1'b1, 28'h0000002, {32'h5, 32'h6, 32'h7, 32'h8}, 1'b1, lat, reqc);
    xfer(1'b0, 28'h0000003, '0, 1'b0, lat, reqc);
    chk("refill_latency", 128'(lat), 128'd6);
    repeat (4) @(negedge clk);
    #1;
    chk("wb_refill_ready_count", 128'(ready_cnt - rc0), 128'd2);
    chk("wb_refill_beats", 128'(log_addr.size()), 128'd8);
    for (int k = 0; k < 8; k++) begin
      chk("wb_refill_addr", 128'((k < log_addr.size()) ? log_addr[k] : 30'h3FFFFFFF), 128'(30'h8 + k));
      chk("wb_refill_we",   128'((k < log_we.size())   ? log_we[k]   : 1'bx),         128'((k < 4) ? 1 : 0));
    end
    chk("refill_line", mem_rdata, 128'h000000B3_000000B2_000000B1_000000B0);

    // Timeout on a read that is never acknowledged.
    mem_noack = 1'b1;
    xfer(1'b0, 28'h0000020, '0, 1'b0, lat, reqc);
    chk("to_req_cycles", 128'(reqc), 128'd7);
    chk("to_latency", 128'(lat), 128'd9);
    chk("to_bus_err", 128'(bus_err), 128'd1);
    chk("to_line_kept", mem_rdata, 128'h000000B3_000000B2_000000B1_000000B0);
    mem_noack = 1'b0;
    repeat (5) @(negedge clk);
    chk("to_bus_err_sticky", 128'(bus_err), 128'd1);
`ifdef MEM_BLOCK_BRIDGE_STATS_EN
    chk("stats_rd_cnt", 128'(rd_cnt), 128'd3);
    chk("stats_wr_cnt", 128'(wr_cnt), 128'd2);
`endif

    // Reset in the middle of beat 2 of a read.
    rd_base  = 32'hC0;
    mem_addr = 28'h0000030;
    mem_read = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_beat2_addr", 128'(dram_addr), 128'(30'hC2));
    #2;
    proc_reset = 1'b1;
    #1;
    chk("rst_mid_dram_req", 128'(dram_req), 128'd0);
    chk("rst_mid_mem_ready", 128'(mem_ready), 128'd0);
    chk("rst_mid_bus_err", 128'(bus_err), 128'd0);
    chk("rst_mid_line", mem_rdata, 128'd0);
    mem_read = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_req", 128'(dram_req), 128'd0);
`ifdef MEM_BLOCK_BRIDGE_STATS_EN
    chk("post_rst_rd_cnt", 128'(rd_cnt), 128'd0);
    chk("post_rst_wr_cnt", 128'(wr_cnt), 128'd0);
`endif

    // Acks while idle must not start or complete anything.
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_ack_req", 128'(dram_req), 128'd0);
    chk("stray_ack_ready", 128'(mem_ready), 128'd0);
    chk("stray_ack_line", mem_rdata, 128'd0);
    stray_ack = 1'b0;
    @(negedge clk);

    clear_log();
    xfer(1'b0, 28'h0000030, '0, 1'b0, lat, reqc);
    chk("post_rst_latency", 128'(lat), 128'd6);
    chk("post_rst_line", mem_rdata, 128'h000000C3_000000C2_000000C1_000000C0);
    chk("post_rst_bus_err", 128'(bus_err), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
